// File: rtl/pic_prog_loader.sv
// pic_prog_loader: ICSP-style bit-serial loader driving the PIC10F20x instruction memory write port.
// Optional write checksum enabled by defining PROG_CSUM_EN.
module pic_prog_loader #(
    parameter int PIC_INSTR_WIDTH        = 12,
    parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
    parameter int PROG_CYCLES            = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              prog_en,
    input  logic                              ser_valid,
    input  logic                              ser_data,
    output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] mem_addr,
    output logic [PIC_INSTR_WIDTH-1:0]        mem_wdata,
    output logic                              mem_we,
    output logic                              cpu_hold,
    output logic                              busy,
    output logic                              err,
    output logic [15:0]                       prog_csum
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_PROG = 2'd3;
    localparam int PCW = $clog2(PROG_CYCLES + 1);
    localparam int AW  = L2_PIC_INSTR_MEM_DEPTH;
    localparam int W   = PIC_INSTR_WIDTH;

    logic [1:0]     state_q, state_d;
    logic [15:0]    sh_q, sh_d, sh_nxt;
    logic [3:0]     cnt_q, cnt_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;
    logic           we_q, we_d, hold_q, hold_d, busy_q, busy_d, err_q, err_d;

    // Bits land at their final position so the whole command/frame is readable on the last strobe.
    assign sh_nxt = sh_q | (16'(ser_data) << cnt_q);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        busy_d  = busy_q;
        err_d   = err_q;
        if (state_q == S_IDLE) begin
            if (prog_en) begin
                state_d = S_CMD;
                addr_d  = '0;
                data_d  = '0;
                err_d   = 1'b0;
                hold_d  = 1'b1;
                sh_d    = '0;
                cnt_d   = '0;
            end
        end else if (!prog_en) begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            sh_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_CMD: if (ser_valid) begin
                    sh_d  = sh_nxt;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd5) begin
                        sh_d  = '0;
                        cnt_d = '0;
                        case (sh_nxt[5:0])
                            6'h02: state_d = S_DATA;
                            6'h06: addr_d = addr_q + AW'(1);
                            6'h08: begin
                                state_d = S_PROG;
                                we_d    = 1'b1;
                                busy_d  = 1'b1;
                                pcnt_d  = PCW'(PROG_CYCLES - 1);
                            end
                            6'h16: addr_d = '0;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_DATA: if (ser_valid) begin
                    sh_d  = sh_nxt;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        sh_d    = '0;
                        cnt_d   = '0;
                        state_d = S_CMD;
                        if (sh_nxt[0] || (|sh_nxt[15:W+1])) err_d = 1'b1;
                        else data_d = sh_nxt[W:1];
                    end
                end
                default: begin
                    if (ser_valid) err_d = 1'b1;
                    if (pcnt_q == '0) begin
                        state_d = S_CMD;
                        busy_d  = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q - PCW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign mem_we    = we_q;
    assign cpu_hold  = hold_q;
    assign busy      = busy_q;
    assign err       = err_q;

`ifdef PROG_CSUM_EN
    logic [15:0] csum_q;
    logic        csum_clr, csum_add;
    assign csum_clr = (state_q == S_IDLE) && prog_en;
    assign csum_add = (state_q == S_CMD) && prog_en && ser_valid && (cnt_q == 4'd5) && (sh_nxt[5:0] == 6'h08);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) csum_q <= '0;
        else if (csum_clr) csum_q <= '0;
        else if (csum_add) csum_q <= csum_q + 16'(data_q);
    end
    assign prog_csum = csum_q;
`else
    assign prog_csum = '0;
`endif
endmodule

// File: tb/tb_pic_prog_loader.sv
// tb_pic_prog_loader: randomized self-checking bench for pic_prog_loader against a command-level model.
module tb_pic_prog_loader;
    localparam int PC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_en = 1'b0, ser_valid = 1'b0, ser_data = 1'b0;
    logic [8:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_we, cpu_hold, busy, err;
    logic [15:0] prog_csum;

    pic_prog_loader #(.PIC_INSTR_WIDTH(12), .L2_PIC_INSTR_MEM_DEPTH(9), .PROG_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .ser_valid(ser_valid), .ser_data(ser_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_hold(cpu_hold),
        .busy(busy), .err(err), .prog_csum(prog_csum)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int m_addr, m_writes;
    logic [11:0] m_data;
    logic [15:0] m_csum;
    bit gap_en = 0;
    logic [8:0]  wq_addr[$];
    logic [11:0] wq_data[$];
    logic        o_we;
    logic [8:0]  o_addr;
    logic [11:0] o_data;
    int          o_busy;

    always @(negedge clk) if (mem_we === 1'b1) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
    end

    function automatic logic [15:0] exp_csum();
`ifdef PROG_CSUM_EN
        return m_csum;
`else
        return 16'h0;
`endif
    endfunction

    task automatic send_bit(input logic b);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            ser_valid = 1'b0;
        end
        @(negedge clk);
        ser_valid = 1'b1;
        ser_data  = b;
    endtask

    task automatic send_cmd(input logic [5:0] c);
        for (int i = 0; i < 6; i++) send_bit(c[i]);
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 0; i < 16; i++) send_bit(f[i]);
    endtask

    task automatic release_ser();
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    task automatic enter();
        @(negedge clk);
        ser_valid = 1'b0;
        prog_en   = 1'b1;
        @(negedge clk);
        m_addr = 0;
        m_data = '0;
        m_csum = '0;
    endtask

    task automatic leave();
        @(negedge clk);
        ser_valid = 1'b0;
        prog_en   = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] w);
        send_cmd(6'h02);
        send_frame({3'b000, w, 1'b0});
        m_data = w;
    endtask

    task automatic do_inc();
        send_cmd(6'h06);
        m_addr = (m_addr + 1) % 512;
    endtask

    task automatic do_prog();
        send_cmd(6'h08);
        @(negedge clk);
        ser_valid = 1'b0;
        o_we   = mem_we;
        o_addr = mem_addr;
        o_data = mem_wdata;
        o_busy = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            o_busy++;
            @(negedge clk);
        end
        m_csum = m_csum + 16'(m_data);
        m_writes++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_wdata, mem_we, cpu_hold, busy, err, prog_csum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {mem_addr, mem_wdata, mem_we, cpu_hold, busy, err, prog_csum});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL idle_hold: got %b required 0", cpu_hold); end
    endtask

    task automatic test_basic();
        enter();
        checks++;
        if (cpu_hold !== 1'b1 || mem_addr !== 9'd0 || err !== 1'b0) begin
            errors++; $display("FAIL entry: hold=%b addr=%h err=%b required 1/0/0", cpu_hold, mem_addr, err);
        end
        do_load(12'hA5C);
        do_prog();
        checks++;
        if (o_we !== 1'b1 || o_addr !== 9'd0 || o_data !== 12'hA5C) begin
            errors++; $display("FAIL basic_write: we=%b addr=%h data=%h required 1/0/a5c", o_we, o_addr, o_data);
        end
        checks++;
        if (o_busy != PC) begin errors++; $display("FAIL basic_busy: got %0d cycles required %0d", o_busy, PC); end
        repeat (2) @(negedge clk);
        checks++;
        if (wq_addr.size() != m_writes) begin errors++; $display("FAIL basic_pulses: got %0d required %0d", wq_addr.size(), m_writes); end
        checks++;
        if (prog_csum !== exp_csum()) begin errors++; $display("FAIL basic_csum: got %h required %h", prog_csum, exp_csum()); end
    endtask

    task automatic test_two_words();
        leave();
        enter();
        do_load(12'h001);
        do_prog();
        do_inc();
        do_load(12'h002);
        do_prog();
        repeat (2) @(negedge clk);
        checks++;
        if (wq_addr.size() != m_writes || wq_addr[$-1] !== 9'd0 || wq_addr[$] !== 9'd1 || wq_data[$-1] !== 12'h001 || wq_data[$] !== 12'h002) begin
            errors++; $display("FAIL two_words: writes=%0d last=%h@%h prev=%h@%h required %0d, 002@001, 001@000",
                wq_addr.size(), wq_data[$], wq_addr[$], wq_data[$-1], wq_addr[$-1], m_writes);
        end
        checks++;
        if (prog_csum !== exp_csum()) begin errors++; $display("FAIL two_csum: got %h required %h", prog_csum, exp_csum()); end
    endtask

    task automatic test_wrap();
        leave();
        enter();
        repeat (511) do_inc();
        release_ser();
        checks++;
        if (mem_addr !== 9'(m_addr) || m_addr != 511) begin errors++; $display("FAIL addr_511: got %0d required %0d", mem_addr, m_addr); end
        do_inc();
        release_ser();
        checks++;
        if (mem_addr !== 9'd0) begin errors++; $display("FAIL addr_wrap: got %0d required 0", mem_addr); end
        repeat (5) do_inc();
        send_cmd(6'h16);
        @(negedge clk);
        ser_valid = 1'b0;
        checks++;
        if (mem_addr !== 9'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_addr: addr=%0d err=%b required 0/0", mem_addr, err); end
        m_addr = 0;
    endtask

    task automatic test_errors();
        int w0;
        leave();
        enter();
        do_load(12'h123);
        w0 = wq_addr.size();
        send_cmd(6'h02);
        send_frame({3'b000, 12'h456, 1'b1});
        release_ser();
        checks++;
        if (err !== 1'b1 || mem_wdata !== 12'h123) begin errors++; $display("FAIL bad_start: err=%b data=%h required 1/123", err, mem_wdata); end
        leave();
        enter();
        checks++;
        if (err !== 1'b0 || mem_wdata !== 12'h000) begin errors++; $display("FAIL err_clear: err=%b data=%h required 0/000", err, mem_wdata); end
        send_cmd(6'h3F);
        release_ser();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL bad_cmd: err=%b required 1", err); end
        leave();
        enter();
        do_load(12'h0F0);
        send_cmd(6'h02);
        send_frame({3'b100, 12'h777, 1'b0});
        release_ser();
        checks++;
        if (err !== 1'b1 || mem_wdata !== 12'h0F0) begin errors++; $display("FAIL bad_stop: err=%b data=%h required 1/0f0", err, mem_wdata); end
        checks++;
        if (wq_addr.size() != w0) begin errors++; $display("FAIL err_no_write: got %0d writes required %0d", wq_addr.size(), w0); end
        leave();
        enter();
        send_cmd(6'h08);
        send_bit(1'b1);
        release_ser();
        repeat (PC + 1) @(negedge clk);
        m_writes++;
        do_inc();
        release_ser();
        checks++;
        if (err !== 1'b1 || mem_addr !== 9'd1) begin errors++; $display("FAIL prog_strobe: err=%b addr=%0d required 1/1", err, mem_addr); end
    endtask

    task automatic test_abort();
        int w0;
        leave();
        enter();
        repeat (3) do_inc();
        do_load(12'h3C3);
        send_cmd(6'h02);
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        w0 = wq_addr.size();
        @(negedge clk);
        ser_valid = 1'b0;
        prog_en   = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_pre: hold=%b required 1", cpu_hold); end
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || mem_addr !== 9'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL abort: hold=%b addr=%0d busy=%b required 0/3/0", cpu_hold, mem_addr, busy);
        end
        repeat (3) @(negedge clk);
        enter();
        checks++;
        if (mem_addr !== 9'd0 || mem_wdata !== 12'h000 || cpu_hold !== 1'b1 || wq_addr.size() != w0) begin
            errors++; $display("FAIL reenter: addr=%0d data=%h hold=%b writes=%0d required 0/000/1/%0d", mem_addr, mem_wdata, cpu_hold, wq_addr.size(), w0);
        end
        do_inc();
        release_ser();
        checks++;
        if (mem_addr !== 9'd1 || err !== 1'b0) begin errors++; $display("FAIL clean_shift: addr=%0d err=%b required 1/0", mem_addr, err); end
        do_load(12'h5A5);
        send_cmd(6'h08);
        @(negedge clk);
        ser_valid = 1'b0;
        prog_en   = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_prog_we: got %b required 1", mem_we); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || wq_addr.size() != w0 + 1) begin
            errors++; $display("FAIL abort_prog: busy=%b hold=%b writes=%0d required 0/0/%0d", busy, cpu_hold, wq_addr.size(), w0 + 1);
        end
        m_writes++;
    endtask

    task automatic test_rst_mid_prog();
        int w0;
        enter();
        do_load(12'hBEE);
        send_cmd(6'h08);
        @(negedge clk);
        ser_valid = 1'b0;
        @(negedge clk);
        w0 = wq_addr.size();
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_we, cpu_hold, busy, err, prog_csum} !== '0) begin
            errors++; $display("FAIL async_rst: got %h required 0", {mem_addr, mem_wdata, mem_we, cpu_hold, busy, err, prog_csum});
        end
        @(negedge clk);
        prog_en = 1'b0;
        rst     = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (wq_addr.size() != w0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++; $display("FAIL rst_no_write: writes=%0d busy=%b hold=%b required %0d/0/0", wq_addr.size(), busy, cpu_hold, w0);
        end
        m_writes = w0;
    endtask

    task automatic test_random();
        gap_en = 1;
        enter();
        for (int k = 0; k < 10; k++) begin
            logic [11:0] w;
            w = 12'($urandom_range(0, 4095));
            do_load(w);
            do_prog();
            checks++;
            if (o_we !== 1'b1 || o_addr !== 9'(m_addr) || o_data !== w || o_busy != PC) begin
                errors++; $display("FAIL rand_write%0d: we=%b addr=%0d data=%h busy=%0d required 1/%0d/%h/%0d", k, o_we, o_addr, o_data, o_busy, m_addr, w, PC);
            end
            repeat ($urandom_range(0, 3)) do_inc();
        end
        release_ser();
        repeat (2) @(negedge clk);
        checks++;
        if (mem_addr !== 9'(m_addr) || prog_csum !== exp_csum() || err !== 1'b0 || wq_addr.size() != m_writes) begin
            errors++; $display("FAIL rand_final: addr=%0d csum=%h err=%b writes=%0d required %0d/%h/0/%0d",
                mem_addr, prog_csum, err, wq_addr.size(), m_addr, exp_csum(), m_writes);
        end
        gap_en = 0;
    endtask

    initial begin
        m_writes = 0;
        test_reset();
        test_basic();
        test_two_words();
        test_wrap();
        test_errors();
        test_abort();
        test_rst_mid_prog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
